// File: rtl/dco_pkg.sv
// Shared types and constants for the DCO frequency-lock controller.
//   dco_state_e : controller FSM states
//   dco_mode_e  : acquisition mode (binary search or fine tracking)
package dco_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned TICK_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned EXT_W  = TICK_W + 1;

    localparam logic [CODE_W-1:0] CENTRAL_CODE = 8'h7F;
    localparam logic [CODE_W-1:0] SAR_INIT     = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_SAR_DECIDE,
        ST_TRACK_DECIDE
    } dco_state_e;

    typedef enum logic {
        MODE_SAR,
        MODE_TRACK
    } dco_mode_e;

endpackage

// File: rtl/dco_period_meter.sv
// Synchronizes the DCO output, detects its rising edges and measures the
// period between consecutive edges in internalClock ticks.
//   dcoSignal_i    : asynchronous DCO output
//   edge_o         : one-cycle pulse per detected rising edge
//   period_o       : ticks between the last two detected edges (saturating)
//   period_valid_o : period_o updated this cycle
//   timeout_o      : no edge seen for at least TIMEOUT ticks
module dco_period_meter
    import dco_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,   // must be >= 2
    parameter int unsigned TIMEOUT     = 32'd1_000_000
) (
    input  logic              internalClock,
    input  logic              reset_i,
    input  logic              dcoSignal_i,
    output logic              edge_o,
    output logic [TICK_W-1:0] period_o,
    output logic              period_valid_o,
    output logic              timeout_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_c;
    logic [TICK_W-1:0]      cnt_q;
    logic [TICK_W-1:0]      cnt_d;

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Ticks since the last edge; restarts at 1 on an edge, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_c) begin
            cnt_d = TICK_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge internalClock or negedge reset_i) begin
        if (!reset_i) begin
            sync_q         <= '0;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            edge_o         <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], dcoSignal_i};
            prev_q         <= sync_q[SYNC_STAGES-1];
            cnt_q          <= cnt_d;
            edge_o         <= rise_c;
            period_valid_o <= rise_c;
            timeout_o      <= (cnt_d >= TIMEOUT);
            if (rise_c) begin
                period_o <= cnt_q;
            end
        end
    end

endmodule

// File: rtl/dco_freq_lock_ctrl.sv
// Frequency-lock controller for a digitally controlled oscillator: an 8-step
// binary search on the code followed by +/-1 tracking around the target period.
//   start_i/stop_i : start acquisition from IDLE / force IDLE (stop wins)
//   targetTicks_i  : desired DCO period, captured at start
//   dcoSignal_i    : asynchronous DCO output
//   freqCode_o     : DCO control code
//   busy_o, locked_o, error_o : status (error_o is a sticky timeout flag)
//   measTicks_o    : most recent completed period measurement
module dco_freq_lock_ctrl
    import dco_pkg::*;
#(
    parameter int unsigned TOL         = 32'd4,
    parameter int unsigned TIMEOUT     = 32'd1_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              internalClock,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [TICK_W-1:0] targetTicks_i,
    input  logic              dcoSignal_i,
    output logic [CODE_W-1:0] freqCode_o,
    output logic              busy_o,
    output logic              locked_o,
    output logic              error_o,
    output logic [TICK_W-1:0] measTicks_o
);

    dco_state_e        state_q, state_d;
    dco_mode_e         mode_q, mode_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TICK_W-1:0] target_q, target_d;
    logic [TICK_W-1:0] meas_q, meas_d;
    logic              locked_q, locked_d;
    logic              error_q, error_d;
    logic              busy_q;

    logic              edge_w;
    logic [TICK_W-1:0] period_w;
    logic              period_valid_w;
    logic              timeout_w;

    logic [CODE_W-1:0] sar_code_c;
    logic [EXT_W-1:0]  win_hi_c;
    logic [EXT_W-1:0]  win_lo_c;
    logic [EXT_W-1:0]  meas_ext_c;

    dco_period_meter #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) u_meter (
        .internalClock  (internalClock),
        .reset_i        (reset_i),
        .dcoSignal_i    (dcoSignal_i),
        .edge_o         (edge_w),
        .period_o       (period_w),
        .period_valid_o (period_valid_w),
        .timeout_o      (timeout_w)
    );

    // State register.
    always_ff @(posedge internalClock or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SAR;
            code_q   <= CENTRAL_CODE;
            idx_q    <= '0;
            target_q <= '0;
            meas_q   <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            meas_q   <= meas_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        code_d   = code_q;
        idx_d    = idx_q;
        target_d = target_q;
        meas_d   = meas_q;
        locked_d = locked_q;
        error_d  = error_q;

        // SAR trial: drop the current bit if the DCO is already too fast, then try the next one.
        sar_code_c = code_q;
        if (meas_q < target_q) begin
            sar_code_c[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
            sar_code_c[idx_q - IDX_W'(1)] = 1'b1;
        end

        // Tracking window in 33 bits so target+TOL cannot wrap; lower bound floored at 0.
        meas_ext_c = {1'b0, meas_q};
        win_hi_c   = {1'b0, target_q} + EXT_W'(TOL);
        win_lo_c   = (target_q >= TOL) ? {1'b0, target_q - TICK_W'(TOL)} : '0;

        if (stop_i) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        target_d = targetTicks_i;
                        error_d  = 1'b0;
                        locked_d = 1'b0;
                        code_d   = SAR_INIT;
                        idx_d    = IDX_W'(CODE_W - 1);
                        mode_d   = MODE_SAR;
                        state_d  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timeout_w) begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (edge_w) begin
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (timeout_w) begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (period_valid_w) begin
                        meas_d  = period_w;
                        state_d = (mode_q == MODE_SAR) ? ST_SAR_DECIDE : ST_TRACK_DECIDE;
                    end
                end
                ST_SAR_DECIDE: begin
                    code_d = sar_code_c;
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else begin
                        mode_d = MODE_TRACK;
                    end
                    state_d = ST_SETTLE;
                end
                ST_TRACK_DECIDE: begin
                    // Larger code means a faster DCO, i.e. a shorter period.
                    if (meas_ext_c > win_hi_c) begin
                        locked_d = 1'b0;
                        if (code_q != '1) begin
                            code_d = code_q + CODE_W'(1);
                        end
                    end else if (meas_ext_c < win_lo_c) begin
                        locked_d = 1'b0;
                        if (code_q != '0) begin
                            code_d = code_q - CODE_W'(1);
                        end
                    end else begin
                        locked_d = 1'b1;
                    end
                    state_d = (code_d != code_q) ? ST_SETTLE : ST_MEASURE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign freqCode_o  = code_q;
    assign busy_o      = busy_q;
    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign measTicks_o = meas_q;

endmodule

// File: tb/tb_dco_freq_lock_ctrl.sv
// Directed bench for dco_freq_lock_ctrl. The DCO model follows
// period = 2*(K - code) ticks with K scaled down from 122198 to 300 so that a
// full acquisition stays short; the targets are scaled with it
// (346 -> code 7F, 204 -> code C6, 80 -> below the fastest period of 90).
module tb_dco_freq_lock_ctrl;

    localparam int unsigned TOL     = 4;
    localparam int unsigned TIMEOUT = 1000;
    localparam int          DCO_K   = 300;

    logic        internalClock = 1'b0;
    logic        reset_i       = 1'b0;
    logic        start_i       = 1'b0;
    logic        stop_i        = 1'b0;
    logic [31:0] targetTicks_i = '0;
    logic        dcoSignal_i   = 1'b0;
    logic [7:0]  freqCode_o;
    logic        busy_o;
    logic        locked_o;
    logic        error_o;
    logic [31:0] measTicks_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit dco_hold = 1'b0;
    int hcnt = 0;

    always #5 internalClock = ~internalClock;

    dco_freq_lock_ctrl #(
        .TOL         (TOL),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .internalClock (internalClock),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .targetTicks_i (targetTicks_i),
        .dcoSignal_i   (dcoSignal_i),
        .freqCode_o    (freqCode_o),
        .busy_o        (busy_o),
        .locked_o      (locked_o),
        .error_o       (error_o),
        .measTicks_o   (measTicks_o)
    );

    // DCO black box: each half period lasts (K - code) ticks; hold forces it low.
    always @(negedge internalClock) begin
        if (dco_hold) begin
            dcoSignal_i = 1'b0;
        end else begin
            hcnt = hcnt + 1;
            if (hcnt >= DCO_K - int'(freqCode_o)) begin
                dcoSignal_i = ~dcoSignal_i;
                hcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start away from a DCO rising edge so no stale edge is in the synchronizer.
    task automatic pulse_start(input logic [31:0] tgt);
        logic prev;
        prev = dcoSignal_i;
        for (int i = 0; i < 1500; i++) begin
            @(posedge internalClock);
            if (prev && !dcoSignal_i) break;
            prev = dcoSignal_i;
        end
        @(negedge internalClock);
        targetTicks_i = tgt;
        start_i = 1'b1;
        @(negedge internalClock);
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge internalClock);
        stop_i = 1'b1;
        @(negedge internalClock);
        stop_i = 1'b0;
    endtask

    task automatic wait_lock(input int budget);
        for (int i = 0; i < budget && locked_o !== 1'b1; i++) @(negedge internalClock);
    endtask

    task automatic wait_code(input logic [7:0] val, input int budget);
        for (int i = 0; i < budget && freqCode_o !== val; i++) @(negedge internalClock);
    endtask

    initial begin
        logic prev;
        bit   seen;

        // Reset values
        repeat (3) @(negedge internalClock);
        check("rst_code",   32'(freqCode_o), 32'h7F);
        check("rst_busy",   32'(busy_o),     32'd0);
        check("rst_locked", 32'(locked_o),   32'd0);
        check("rst_error",  32'(error_o),    32'd0);
        check("rst_meas",   measTicks_o,     32'd0);
        reset_i = 1'b1;
        repeat (5) @(negedge internalClock);

        // Target exactly at code 7F
        pulse_start(32'd346);
        check("t1_code_init", 32'(freqCode_o), 32'h80);
        check("t1_busy",      32'(busy_o),     32'd1);
        wait_lock(12000);
        check("t1_locked", 32'(locked_o),   32'd1);
        check("t1_code",   32'(freqCode_o), 32'h7F);
        check("t1_meas",   measTicks_o,     32'd346);
        check("t1_error",  32'(error_o),    32'd0);
        repeat (800) @(negedge internalClock);
        check("t1_hold_locked", 32'(locked_o),   32'd1);
        check("t1_hold_code",   32'(freqCode_o), 32'h7F);

        pulse_stop();
        check("stop1_busy",   32'(busy_o),     32'd0);
        check("stop1_locked", 32'(locked_o),   32'd0);
        check("stop1_code",   32'(freqCode_o), 32'h7F);

        // Target at code C6, with an ignored start mid-search
        pulse_start(32'd204);
        wait_code(8'hC0, 3000);
        @(negedge internalClock);
        targetTicks_i = 32'd346;
        start_i = 1'b1;
        @(negedge internalClock);
        start_i = 1'b0;
        wait_lock(12000);
        check("t2_locked", 32'(locked_o),   32'd1);
        check("t2_code",   32'(freqCode_o), 32'hC6);
        check("t2_meas",   measTicks_o,     32'd204);
        pulse_stop();

        // Unreachable target: code saturates at FF, never locks
        pulse_start(32'd80);
        repeat (6000) @(negedge internalClock);
        check("t3_code",   32'(freqCode_o), 32'hFF);
        check("t3_locked", 32'(locked_o),   32'd0);
        check("t3_busy",   32'(busy_o),     32'd1);
        check("t3_error",  32'(error_o),    32'd0);
        check("t3_meas",   measTicks_o,     32'd90);
        pulse_stop();

        // Stop beats a simultaneous start in IDLE
        @(negedge internalClock);
        targetTicks_i = 32'd346;
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge internalClock);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("stopwin_busy", 32'(busy_o),     32'd0);
        check("stopwin_code", 32'(freqCode_o), 32'hFF);

        // Stop while trying bit 4, then restart
        pulse_start(32'd346);
        wait_code(8'h70, 4000);
        pulse_stop();
        check("t4_stop_busy", 32'(busy_o),     32'd0);
        check("t4_stop_code", 32'(freqCode_o), 32'h70);
        repeat (1000) @(negedge internalClock);
        check("t4_idle_code", 32'(freqCode_o), 32'h70);
        check("t4_idle_busy", 32'(busy_o),     32'd0);
        pulse_start(32'd346);
        check("t4_restart_code", 32'(freqCode_o), 32'h80);
        wait_lock(12000);
        check("t4_locked", 32'(locked_o),   32'd1);
        check("t4_code",   32'(freqCode_o), 32'h7F);
        check("t4_meas",   measTicks_o,     32'd346);
        pulse_stop();

        // Timeout: DCO dies right after the settle edge
        pulse_start(32'd346);
        prev = dcoSignal_i;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge internalClock);
            if (dcoSignal_i && !prev) begin
                seen = 1'b1;
                break;
            end
            prev = dcoSignal_i;
        end
        dco_hold = 1'b1;
        check("to_rise_seen", 32'(seen), 32'd1);
        repeat (TIMEOUT + 1) @(posedge internalClock);
        #1;
        check("to_early_error", 32'(error_o), 32'd0);
        check("to_early_busy",  32'(busy_o),  32'd1);
        @(posedge internalClock);
        #1;
        check("to_error",  32'(error_o),    32'd1);
        check("to_busy",   32'(busy_o),     32'd0);
        check("to_code",   32'(freqCode_o), 32'h80);
        check("to_locked", 32'(locked_o),   32'd0);
        dco_hold = 1'b0;
        pulse_start(32'd346);
        check("to_clear_error", 32'(error_o), 32'd0);
        check("to_clear_busy",  32'(busy_o),  32'd1);

        // Asynchronous reset while tracking
        wait_lock(12000);
        check("t5_locked", 32'(locked_o), 32'd1);
        @(posedge internalClock);
        #3;
        reset_i = 1'b0;
        #1;
        check("arst_code",   32'(freqCode_o), 32'h7F);
        check("arst_busy",   32'(busy_o),     32'd0);
        check("arst_locked", 32'(locked_o),   32'd0);
        check("arst_error",  32'(error_o),    32'd0);
        check("arst_meas",   measTicks_o,     32'd0);
        repeat (2) @(negedge internalClock);
        reset_i = 1'b1;
        repeat (2000) @(negedge internalClock);
        check("post_rst_code", 32'(freqCode_o), 32'h7F);
        check("post_rst_busy", 32'(busy_o),     32'd0);
        check("post_rst_meas", measTicks_o,     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
